// File: rtl/mem_arbiter.sv
// Three-way SRAM arbiter for VGA scanout, CPU fetch and CPU load/store.
// MEM_ARB_STARVE_GUARD_EN lets a starved CPU requester outrank VGA.
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int L = MEM_LATENCY;
  localparam logic [1:0] ID_VGA   = 2'd0;
  localparam logic [1:0] ID_FETCH = 2'd1;
  localparam logic [1:0] ID_DATA  = 2'd2;

  logic         last_cpu;
  logic         fetch_starve;
  logic         data_starve;
  logic         g_vga, g_fetch, g_data;
  logic         rd_issue;
  logic [1:0]   issue_id;
  logic [L-1:0] tag_v;
  logic [1:0]   tag_id [L];

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] fetch_wait;
  logic [3:0] data_wait;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      fetch_wait <= '0;
      data_wait  <= '0;
    end else begin
      if (g_fetch)
        fetch_wait <= '0;
      else if (fetch_req && fetch_wait != 4'd15)
        fetch_wait <= fetch_wait + 4'd1;
      if (g_data)
        data_wait <= '0;
      else if (data_req && data_wait != 4'd15)
        data_wait <= data_wait + 4'd1;
    end
  end

  assign fetch_starve = fetch_req & fetch_wait[3];
  assign data_starve  = data_req & data_wait[3];
`else
  assign fetch_starve = 1'b0;
  assign data_starve  = 1'b0;
`endif

  // last_cpu=1 means data was served last, so fetch wins a tie
  always_comb begin
    g_vga   = 1'b0;
    g_fetch = 1'b0;
    g_data  = 1'b0;
    if (fetch_starve && data_starve) begin
      g_fetch = last_cpu;
      g_data  = ~last_cpu;
    end else if (fetch_starve) begin
      g_fetch = 1'b1;
    end else if (data_starve) begin
      g_data = 1'b1;
    end else if (vga_req) begin
      g_vga = 1'b1;
    end else if (fetch_req && data_req) begin
      g_fetch = last_cpu;
      g_data  = ~last_cpu;
    end else begin
      g_fetch = fetch_req;
      g_data  = data_req;
    end
    if (rst_async) begin
      g_vga   = 1'b0;
      g_fetch = 1'b0;
      g_data  = 1'b0;
    end
  end

  assign vga_gnt   = g_vga;
  assign fetch_gnt = g_fetch;
  assign data_gnt  = g_data;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    issue_id  = ID_VGA;
    unique case (1'b1)
      g_vga: begin
        mem_en   = 1'b1;
        mem_addr = vga_addr;
      end
      g_fetch: begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr;
        issue_id = ID_FETCH;
      end
      g_data: begin
        mem_en    = 1'b1;
        mem_we    = data_we;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        issue_id  = ID_DATA;
      end
      default: ;
    endcase
  end

  assign rd_issue = mem_en & ~mem_we;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      last_cpu <= 1'b1;
    end else if (g_fetch) begin
      last_cpu <= 1'b0;
    end else if (g_data) begin
      last_cpu <= 1'b1;
    end
  end

  // Clearing the tags on reset drops any read still in flight
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      tag_v <= '0;
      for (int i = 0; i < L; i++)
        tag_id[i] <= ID_VGA;
    end else begin
      tag_v[0]  <= rd_issue;
      tag_id[0] <= issue_id;
      for (int i = 1; i < L; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign vga_rvalid   = ~rst_async & tag_v[L-1]
                      & (tag_id[L-1] == ID_VGA);
  assign fetch_rvalid = ~rst_async & tag_v[L-1]
                      & (tag_id[L-1] == ID_FETCH);
  assign data_rvalid  = ~rst_async & tag_v[L-1]
                      & (tag_id[L-1] == ID_DATA);
  assign rdata = rst_async ? '0 : mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 2-cycle SRAM model.
// Starvation expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_async;
  logic        vga_req, fetch_req, data_req, data_we;
  logic [15:0] vga_addr, fetch_addr, data_addr, data_wdata;
  logic        vga_gnt, fetch_gnt, data_gnt;
  logic        vga_rvalid, fetch_rvalid, data_rvalid;
  logic [15:0] rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] mem [0:65535];
  logic [15:0] rd_p0 = '0;
  logic [15:0] rd_p1 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst_async(rst_async),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid),
    .data_req(data_req), .data_we(data_we),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en && mem_we)
      mem[mem_addr] <= mem_wdata;
    rd_p0 <= (mem_en && !mem_we) ? mem[mem_addr] : 16'h0;
    rd_p1 <= rd_p0;
  end
  assign mem_rdata = rd_p1;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc;
    @(negedge clk);
  endtask

  task automatic settle;
    #1;
  endtask

  function automatic logic [2:0] gnts();
    return {vga_gnt, fetch_gnt, data_gnt};
  endfunction

  function automatic logic [2:0] rvs();
    return {vga_rvalid, fetch_rvalid, data_rvalid};
  endfunction

  task automatic idle;
    vga_req = 0; fetch_req = 0; data_req = 0; data_we = 0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++)
      mem[i] = init_val(16'(i));
    rst_async = 1; idle();
    vga_addr = 16'h0; fetch_addr = 16'h0;
    data_addr = 16'h0; data_wdata = 16'h0;

    // reset: outputs forced low even with requests pending
    next_cyc();
    vga_req = 1; fetch_req = 1; data_req = 1;
    vga_addr = 16'h1234; data_wdata = 16'hFFFF;
    settle();
    chk("rst_gnt", 32'(gnts()), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_rv", 32'(rvs()), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    next_cyc(); rst_async = 0; idle(); settle();
    chk("idle_mem_en", 32'(mem_en), 32'h0);

    // single fetch read
    next_cyc(); fetch_req = 1; fetch_addr = 16'h0010; settle();
    chk("f1_gnt", 32'(gnts()), 32'b010);
    chk("f1_addr", 32'(mem_addr), 32'h0010);
    chk("f1_we", 32'(mem_we), 32'h0);
    next_cyc(); idle(); settle();
    chk("f1_rv_c1", 32'(rvs()), 32'b000);
    next_cyc(); settle();
    chk("f1_rv_c2", 32'(rvs()), 32'b010);
    chk("f1_rdata", 32'(rdata), 32'hA5B5);
    next_cyc(); settle();
    chk("f1_rv_c3", 32'(rvs()), 32'b000);

    // store then load same address
    next_cyc(); data_req = 1; data_we = 1;
    data_addr = 16'h0200; data_wdata = 16'hBEEF; settle();
    chk("st_gnt", 32'(gnts()), 32'b001);
    chk("st_we", 32'(mem_we), 32'h1);
    chk("st_wdata", 32'(mem_wdata), 32'hBEEF);
    next_cyc(); data_we = 0; settle();
    chk("ld_gnt", 32'(gnts()), 32'b001);
    chk("ld_we", 32'(mem_we), 32'h0);
    chk("ld_rv_c1", 32'(rvs()), 32'b000);
    next_cyc(); idle(); settle();
    chk("ld_rv_c2", 32'(rvs()), 32'b000);
    next_cyc(); settle();
    chk("ld_rv_c3", 32'(rvs()), 32'b001);
    chk("ld_rdata", 32'(rdata), 32'hBEEF);
    next_cyc(); settle();
    chk("ld_rv_c4", 32'(rvs()), 32'b000);

    // round-robin fetch/data
    next_cyc(); fetch_req = 1; data_req = 1;
    fetch_addr = 16'h0100; data_addr = 16'h0300; settle();
    chk("rr_g0", 32'(gnts()), 32'b010);
    next_cyc(); settle();
    chk("rr_g1", 32'(gnts()), 32'b001);
    next_cyc(); settle();
    chk("rr_g2", 32'(gnts()), 32'b010);
    chk("rr_rv2", 32'(rvs()), 32'b010);
    chk("rr_rd2", 32'(rdata), 32'(init_val(16'h0100)));
    next_cyc(); settle();
    chk("rr_g3", 32'(gnts()), 32'b001);
    chk("rr_rv3", 32'(rvs()), 32'b001);
    chk("rr_rd3", 32'(rdata), 32'(init_val(16'h0300)));
    next_cyc(); idle(); settle();
    chk("rr_rv4", 32'(rvs()), 32'b010);
    next_cyc(); settle();
    chk("rr_rv5", 32'(rvs()), 32'b001);
    next_cyc(); settle();
    chk("rr_rv6", 32'(rvs()), 32'b000);

    // VGA priority with all three requesting
    next_cyc(); vga_req = 1; fetch_req = 1; data_req = 1;
    vga_addr = 16'h0400; fetch_addr = 16'h0500;
    data_addr = 16'h0600; settle();
    chk("vp_g0", 32'(gnts()), 32'b100);
    chk("vp_addr0", 32'(mem_addr), 32'h0400);
    next_cyc(); vga_req = 0; settle();
    chk("vp_g1", 32'(gnts()), 32'b010);
    next_cyc(); fetch_req = 0; settle();
    chk("vp_g2", 32'(gnts()), 32'b001);
    chk("vp_rv2", 32'(rvs()), 32'b100);
    chk("vp_rd2", 32'(rdata), 32'(init_val(16'h0400)));
    next_cyc(); idle(); settle();
    chk("vp_rv3", 32'(rvs()), 32'b010);
    chk("vp_rd3", 32'(rdata), 32'(init_val(16'h0500)));
    next_cyc(); settle();
    chk("vp_rv4", 32'(rvs()), 32'b001);
    chk("vp_rd4", 32'(rdata), 32'(init_val(16'h0600)));
    next_cyc(); settle();

    // reset while a fetch read is in flight
    next_cyc(); fetch_req = 1; fetch_addr = 16'h0020; settle();
    chk("rm_g0", 32'(gnts()), 32'b010);
    next_cyc(); rst_async = 1;
    vga_req = 1; fetch_req = 1; data_req = 1; settle();
    chk("rm_rst_gnt", 32'(gnts()), 32'b000);
    chk("rm_rst_en", 32'(mem_en), 32'h0);
    chk("rm_rst_rv", 32'(rvs()), 32'b000);
    chk("rm_rst_rdata", 32'(rdata), 32'h0);
    next_cyc(); rst_async = 0; vga_req = 0;
    data_addr = 16'h0030; settle();
    chk("rm_rv_drop", 32'(rvs()), 32'b000);
    chk("rm_tie_fetch", 32'(gnts()), 32'b010);
    next_cyc(); fetch_req = 0; settle();
    chk("rm_g3", 32'(gnts()), 32'b001);
    chk("rm_rv3", 32'(rvs()), 32'b000);
    next_cyc(); idle(); settle();
    chk("rm_rv4", 32'(rvs()), 32'b010);
    chk("rm_rd4", 32'(rdata), 32'(init_val(16'h0020)));
    next_cyc(); settle();
    chk("rm_rv5", 32'(rvs()), 32'b001);
    next_cyc(); settle();

    // continuous VGA against a waiting fetch
    next_cyc(); vga_req = 1; fetch_req = 1;
    vga_addr = 16'h0700; fetch_addr = 16'h0800;
    for (int k = 0; k < 12; k++) begin
      settle();
`ifdef MEM_ARB_STARVE_GUARD_EN
      chk($sformatf("sv_g%0d", k), 32'(gnts()),
          (k == 8) ? 32'b010 : 32'b100);
`else
      chk($sformatf("sv_g%0d", k), 32'(gnts()), 32'b100);
`endif
      next_cyc();
      if (fetch_gnt === 1'b1) fetch_req = 0;
    end
    idle();
    repeat (4) next_cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port system SRAM between three requesters: VGA scanout (vga_*), CPU instruction fetch (fetch_*) and CPU load/store (data_*).
- Issues at most one memory access per cycle. Tracks in-flight reads through a tag pipeline of length MEM_LATENCY and routes each returned word to its requester.
- Sits between the CPU fetch unit, the CPU load/store path, the VGA pixel fetcher and the SRAM port.

Parameters:
- ADDR_W, 16, memory address width in bits
- DATA_W, 16, memory data width in bits
- MEM_LATENCY, 2, cycles from an issued read (mem_en=1, mem_we=0 at posedge) to mem_rdata valid; legal range 1..4

Ports:
- clk  in  1  clock
- rst_async  in  1  asynchronous active-high reset
- vga_req  in  1  VGA read request
- vga_addr  in  ADDR_W  VGA read address
- vga_gnt  out  1  VGA request accepted this cycle
- vga_rvalid  out  1  rdata holds VGA read result
- fetch_req  in  1  instruction fetch read request
- fetch_addr  in  ADDR_W  fetch address
- fetch_gnt  out  1  fetch request accepted this cycle
- fetch_rvalid  out  1  rdata holds fetch result
- data_req  in  1  load/store request
- data_we  in  1  1=store, 0=load
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_gnt  out  1  load/store accepted this cycle
- data_rvalid  out  1  rdata holds load result (never asserted for stores)
- rdata  out  DATA_W  shared read data; equals mem_rdata
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Handshake:
  - A requester holds req high with stable addr/we/wdata until it sees gnt=1 at a posedge.
  - gnt is combinational from the req inputs and arbiter state, and is one-hot or zero.
  - Transfer occurs on the posedge where req&gnt=1.
  - A requester may keep req high on the following cycle to issue back-to-back accesses.
- Memory issue:
  - mem_en = OR of all gnts.
  - mem_addr, mem_we and mem_wdata are muxed from the granted requester in the same cycle.
  - When no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Priority:
  - VGA is always first.
  - Between fetch and data, round-robin via a 1-bit pointer last_cpu (0=fetch last served).
  - If both CPU requesters are pending, the one not last served wins.
  - last_cpu updates only when a CPU requester is granted.
- Read return:
  - Tag pipeline of MEM_LATENCY stages. Each stage = {valid, id[1:0]} with id 0=VGA, 1=fetch, 2=data.
  - A granted read enters stage 0 at its grant edge and advances one stage per cycle.
  - The matching *_rvalid is asserted combinationally from the last stage, exactly MEM_LATENCY cycles after the grant edge, for exactly one cycle.
  - Stores enter no tag.
  - Reads return strictly in issue order.
  - Back-to-back reads give one rvalid per cycle.
- Stores complete at their grant edge. A store followed by a load to the same address returns the new data.
- Reset (asynchronous, any time):
  - Tag pipeline cleared, last_cpu=1 (fetch wins first tie), starvation counters=0.
  - In-flight reads are dropped: no rvalid is produced for them after reset.
  - All outputs are 0 while rst_async is high.
- Simultaneous events:
  - A grant and a return for the same requester in the same cycle are independent.
  - All three requesting: VGA granted; the CPU requester chosen by last_cpu is granted on the next free cycle.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- With the macro defined:
  - Each CPU requester has a 4-bit wait counter.
  - The counter increments each cycle its req=1 and gnt=0, saturating at 15.
  - The counter clears on grant.
  - When a counter reaches 8, that requester outranks VGA for its next grant.
  - If both counters are at 8 or above, round-robin decides between them.
- Without the macro: no counters exist, and VGA has strict priority, which can starve the CPU indefinitely.

Test Plan:
- Single fetch read, MEM_LATENCY=2: fetch_req=1, addr=0x0010 at cycle 0 -> fetch_gnt=1 at cycle 0, mem_addr=0x0010, mem_we=0; fetch_rvalid=1 at cycle 2 with rdata=mem content; no other rvalid.
- Store then load: data store 0xBEEF to 0x0200, then data load 0x0200 on the next cycle -> two consecutive data_gnt; data_rvalid only for the load, 2 cycles after its grant, rdata=0xBEEF.
- Round-robin: fetch_req and data_req held high for 4 cycles after reset, both reads, no VGA -> grants alternate fetch, data, fetch, data; rvalids alternate in the same order.
- VGA priority: all three req=1 on the same cycle -> vga_gnt first; fetch then data on the following cycles; rvalids return in order VGA, fetch, data.
- Reset mid-flight: grant fetch read at cycle 0, assert rst_async at cycle 1 for one cycle -> no fetch_rvalid at cycle 2; all outputs 0 during reset; the first tie after reset goes to fetch.
- MEM_ARB_STARVE_GUARD_EN: vga_req held high continuously, fetch_req=1 from cycle 0 -> fetch_gnt=1 at cycle 8, VGA granted on all other cycles. Without the macro, fetch_gnt is never asserted.
